// File: rtl/serial_subtractor.sv
// ============================================================================
// Module   : serial_subtractor
// Brief    : Bit-serial unsigned subtractor (a - b [- bin]), LSB first, one
//            full-subtractor cell with a registered borrow. Optional borrow-in
//            port enabled by defining SERIAL_SUB_BORROW_IN_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef SERIAL_SUB_BORROW_IN_EN
    input  logic             bin,
`endif
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             busy,
    output logic             done
);

    localparam int               C_CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [C_CW-1:0]  C_CNT_LAST = C_CW'(WIDTH - 1);

    localparam logic [1:0] C_IDLE  = 2'd0;
    localparam logic [1:0] C_SHIFT = 2'd1;
    localparam logic [1:0] C_DONE  = 2'd2;

    logic [1:0]       state_q,   state_d;
    logic [WIDTH-1:0] a_sh_q,    a_sh_d;
    logic [WIDTH-1:0] b_sh_q,    b_sh_d;
    logic [WIDTH-1:0] res_q,     res_d;
    logic             borrow_q,  borrow_d;
    logic [C_CW-1:0]  cnt_q,     cnt_d;
    logic [WIDTH-1:0] diff_q,    diff_d;
    logic             bout_q,    bout_d;

    logic w_bin_init;
    logic w_load;
    logic w_last;
    logic w_x, w_y, w_d, w_r_next;

`ifdef SERIAL_SUB_BORROW_IN_EN
    assign w_bin_init = bin;
`else
    assign w_bin_init = 1'b0;
`endif

    // DONE accepts a new request exactly like IDLE, giving back-to-back operation
    assign w_load = start && ((state_q == C_IDLE) || (state_q == C_DONE));
    assign w_last = (cnt_q == C_CNT_LAST);

    assign w_x      = a_sh_q[0];
    assign w_y      = b_sh_q[0];
    assign w_d      = w_x ^ w_y ^ borrow_q;
    assign w_r_next = (~w_x & w_y) | (~(w_x ^ w_y) & borrow_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= C_IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            res_q    <= '0;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
            diff_q   <= '0;
            bout_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            res_q    <= res_d;
            borrow_q <= borrow_d;
            cnt_q    <= cnt_d;
            diff_q   <= diff_d;
            bout_q   <= bout_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            C_IDLE:  if (start)  state_d = C_SHIFT;
            C_SHIFT: if (w_last) state_d = C_DONE;
            C_DONE:  state_d = start ? C_SHIFT : C_IDLE;
            default: state_d = C_IDLE;
        endcase
    end

    always_comb begin
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        res_d    = res_q;
        borrow_d = borrow_q;
        cnt_d    = cnt_q;
        diff_d   = diff_q;
        bout_d   = bout_q;
        if (w_load) begin
            a_sh_d   = a;
            b_sh_d   = b;
            res_d    = '0;
            borrow_d = w_bin_init;
            cnt_d    = '0;
        end else if (state_q == C_SHIFT) begin
            a_sh_d   = {1'b0, a_sh_q[WIDTH-1:1]};
            b_sh_d   = {1'b0, b_sh_q[WIDTH-1:1]};
            res_d    = {w_d, res_q[WIDTH-1:1]};
            borrow_d = w_r_next;
            cnt_d    = cnt_q + 1'b1;
            // Result registers change only on DONE entry so partial sums never leak out
            if (w_last) begin
                diff_d = {w_d, res_q[WIDTH-1:1]};
                bout_d = w_r_next;
            end
        end
    end

    always_comb begin
        busy = (state_q == C_SHIFT);
        done = (state_q == C_DONE);
        diff = diff_q;
        bout = bout_q;
    end

endmodule

`default_nettype wire
